// File: rtl/mem_arb_pkg.sv
// Shared definitions for the RAM arbiter family: FSM state encoding,
// port identifiers and default bus widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the port that was not
// served last wins; a lone requester always wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = req_a | req_b;
        gnt_id    = PORT_A;
        if (req_a && req_b) begin
            gnt_id = ~last;
        end else if (req_b) begin
            gnt_id = PORT_B;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter/sequencer for a 512x32 single-port RAM.
// Each access runs IDLE (grant + latch) -> BUSY (RAM cycle) -> RESP (ack).
module ram_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              clr,

    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              ack_a,
    output logic [DATA_W-1:0] rdata_a,

    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_b,

    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,

    output logic              busy
);

    state_t              state_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic                id_reg;
    logic                last_reg;

    logic                gnt_valid;
    logic                gnt_id;

    rr_arb2 u_rr_arb2 (
        .req_a     (req_a),
        .req_b     (req_b),
        .last      (last_reg),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= ST_IDLE;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            id_reg    <= PORT_A;
            last_reg  <= PORT_B;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        id_reg    <= gnt_id;
                        we_reg    <= (gnt_id == PORT_B) ? we_b    : we_a;
                        addr_reg  <= (gnt_id == PORT_B) ? addr_b  : addr_a;
                        wdata_reg <= (gnt_id == PORT_B) ? wdata_b : wdata_a;
                        state_reg <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    state_reg <= ST_RESP;
                end
                ST_RESP: begin
                    last_reg  <= id_reg;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-port read-data register and ack decode; only the winner's register
    // captures ram_dout, and only for reads.
    logic [1:0] ack_vec;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_W-1:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (clr) begin
                    rdata_reg <= '0;
                end else if (state_reg == ST_BUSY && !we_reg && id_reg == 1'(gi)) begin
                    rdata_reg <= ram_dout;
                end
            end

            assign ack_vec[gi] = (state_reg == ST_RESP) && (id_reg == 1'(gi));
        end
    endgenerate

    assign ack_a   = ack_vec[0];
    assign ack_b   = ack_vec[1];
    assign rdata_a = g_port[0].rdata_reg;
    assign rdata_b = g_port[1].rdata_reg;

    // clr blocks the write strobe immediately so an aborted write never lands.
    assign ram_read  = (state_reg == ST_BUSY) && !we_reg;
    assign ram_write = (state_reg == ST_BUSY) && we_reg && !clr;
    assign ram_addr  = addr_reg;
    assign ram_din   = wdata_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 512x32 RAM.
module tb_ram_arbiter;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              clr;
    logic              req_a, we_a, req_b, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] wdata_a, wdata_b;
    logic              ack_a, ack_b;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              ram_read, ram_write, busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din, ram_dout;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .clr       (clr),
        .req_a     (req_a),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .wdata_a   (wdata_a),
        .ack_a     (ack_a),
        .rdata_a   (rdata_a),
        .req_b     (req_b),
        .we_b      (we_b),
        .addr_b    (addr_b),
        .wdata_b   (wdata_b),
        .ack_b     (ack_b),
        .rdata_b   (rdata_b),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .busy      (busy)
    );

    // Behavioural RAM: synchronous write, combinational read.
    logic [DATA_W-1:0] mem [512];

    initial begin
        for (int i = 0; i < 512; i++) mem[i] <= '0;
        mem[9'h068] <= 32'h0000_0055;
        mem[9'h001] <= 32'h1111_1111;
        mem[9'h002] <= 32'h2222_2222;
    end

    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_din;
    end

    assign ram_dout = mem[ram_addr];

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        clr = 1'b1;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;

        // Reset state
        step(2);
        clr = 1'b0;
        chk("reset_ctl", {27'd0, ack_a, ack_b, ram_read, ram_write, busy}, 32'd0);
        chk("reset_rdata_a", rdata_a, 32'd0);
        chk("reset_rdata_b", rdata_b, 32'd0);
        chk("reset_ram_addr", 32'(ram_addr), 32'd0);
        chk("reset_ram_din", ram_din, 32'd0);
        $display("txn reset done");

        // A reads 0x068
        req_a = 1'b1; we_a = 1'b0; addr_a = 9'h068;
        step();
        chk("rd_c1_busy", {30'd0, busy, ram_read}, 32'd3);
        chk("rd_c1_addr", 32'(ram_addr), 32'h068);
        chk("rd_c1_ack_a", 32'(ack_a), 32'd0);
        step();
        chk("rd_c2_ack", {30'd0, ack_a, ack_b}, 32'd2);
        chk("rd_c2_rdata_a", rdata_a, 32'h0000_0055);
        chk("rd_c2_rdata_b", rdata_b, 32'd0);
        chk("rd_c2_ram_idle", {30'd0, ram_read, ram_write}, 32'd0);
        req_a = 1'b0;
        step();
        chk("rd_c3_idle", {29'd0, ack_a, ack_b, busy}, 32'd0);
        $display("txn A read 0x068 -> 0x%08h", rdata_a);

        // B writes 0xDEADBEEF to 0x12C, then A reads it back
        req_b = 1'b1; we_b = 1'b1; addr_b = 9'h12C; wdata_b = 32'hDEAD_BEEF;
        step();
        chk("wr_c1_strobes", {30'd0, ram_read, ram_write}, 32'd1);
        chk("wr_c1_din", ram_din, 32'hDEAD_BEEF);
        step();
        chk("wr_c2_ack", {30'd0, ack_a, ack_b}, 32'd1);
        chk("wr_c2_rdata_b", rdata_b, 32'd0);
        req_b = 1'b0; we_b = 1'b0;
        req_a = 1'b1; we_a = 1'b0; addr_a = 9'h12C;
        step(3);
        chk("wr_c5_ack", {30'd0, ack_a, ack_b}, 32'd2);
        chk("wr_c5_rdata_a", rdata_a, 32'hDEAD_BEEF);
        chk("wr_c5_rdata_b", rdata_b, 32'd0);
        req_a = 1'b0;
        step();
        $display("txn B write 0x12C, A read back 0x%08h", rdata_a);

        // A writes 0x010 and clr lands in BUSY; last served was A
        req_a = 1'b1; we_a = 1'b1; addr_a = 9'h010; wdata_a = 32'h1234_5678;
        step();
        chk("abort_c1_busy", 32'(busy), 32'd1);
        clr = 1'b1;
        req_a = 1'b0; we_a = 1'b0;
        #1;
        chk("abort_write_gated", 32'(ram_write), 32'd0);
        step();
        clr = 1'b0;
        chk("abort_no_ack", {29'd0, ack_a, ack_b, busy}, 32'd0);
        // Pointer back at B: a tie must go to A
        req_a = 1'b1; addr_a = 9'h010;
        req_b = 1'b1; we_b = 1'b0; addr_b = 9'h001;
        step(2);
        chk("abort_tie_ack", {30'd0, ack_a, ack_b}, 32'd2);
        chk("abort_old_value", rdata_a, 32'd0);
        req_a = 1'b0;
        step(3);
        chk("abort_b_ack", {30'd0, ack_a, ack_b}, 32'd1);
        chk("abort_b_rdata", rdata_b, 32'h1111_1111);
        req_b = 1'b0;
        step();
        $display("txn aborted write 0x010, read back 0x%08h", rdata_a);

        // Tie from reset: both held for four accesses -> A, B, A, B
        clr = 1'b1;
        req_a = 1'b1; we_a = 1'b0; addr_a = 9'h068;
        req_b = 1'b1; we_b = 1'b0; addr_b = 9'h12C;
        step(2);
        clr = 1'b0;
        step(2);
        chk("tie_c2_ack", {30'd0, ack_a, ack_b}, 32'd2);
        chk("tie_c2_rdata_a", rdata_a, 32'h0000_0055);
        step();
        chk("tie_c3_noack", {30'd0, ack_a, ack_b}, 32'd0);
        step(2);
        chk("tie_c5_ack", {30'd0, ack_a, ack_b}, 32'd1);
        chk("tie_c5_rdata_b", rdata_b, 32'hDEAD_BEEF);
        step(3);
        chk("tie_c8_ack", {30'd0, ack_a, ack_b}, 32'd2);
        step(3);
        chk("tie_c11_ack", {30'd0, ack_a, ack_b}, 32'd1);
        req_a = 1'b0; req_b = 1'b0;
        step();
        $display("txn tie sequence A,B,A,B complete");

        // B fields change while A is served; B stays high after its ack
        req_a = 1'b1; we_a = 1'b0; addr_a = 9'h068;
        req_b = 1'b1; we_b = 1'b0; addr_b = 9'h001;
        step();
        addr_b = 9'h002;
        step();
        chk("fld_c2_ack", {30'd0, ack_a, ack_b}, 32'd2);
        req_a = 1'b0;
        step(2);
        chk("fld_c4_addr", 32'(ram_addr), 32'h002);
        step();
        chk("fld_c5_ack", {30'd0, ack_a, ack_b}, 32'd1);
        chk("fld_c5_rdata_b", rdata_b, 32'h2222_2222);
        addr_b = 9'h001;
        step(3);
        chk("fld_c8_ack", {30'd0, ack_a, ack_b}, 32'd1);
        chk("fld_c8_rdata_b", rdata_b, 32'h1111_1111);
        req_b = 1'b0;
        step();
        $display("txn B latched 0x002 then repeat access 0x001");

        // Idle for 20 cycles
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_quiet", {27'd0, ram_read, ram_write, busy, ack_a, ack_b}, 32'd0);
        end
        $display("txn idle 20 cycles");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
